// File: rtl/pe_driver.sv
// pe_driver: host-side driver that serialises operands into one bit-serial PDE element and reads back its result.
// Readback path (READ state, read, out_solution) is enabled by defining PE_DRIVER_READBACK_EN.
module pe_driver #(
  parameter int W     = 8,
  parameter int ITERS = 1
) (
  input  logic         clka,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_left,
  input  logic [W-1:0] in_top,
  input  logic [W-1:0] in_right,
  input  logic [W-1:0] in_down,
  output logic         mode,
  output logic         read,
  output logic         left,
  output logic         top,
  output logic         right,
  output logic         down,
  output logic         step_a,
  output logic         step_b,
  input  logic         residue,
  input  logic         solution,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_solution,
  output logic         out_residue_nz,
  output logic         busy
);

  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE, LOAD, COMMIT, ITER, ITER_COMMIT,
`ifdef PE_DRIVER_READBACK_EN
    READ,
`endif
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [CW-1:0]  r_bitCnt;
  logic [3:0]     r_iter;
  logic [4:0]     w_iterNext;
  logic           w_bitLast;
  logic           w_moreIters;
  logic           w_lastPassEntry;
  logic           w_accept;
  logic           w_nextRead;
  logic [W-1:0]   r_shL, r_shT, r_shR, r_shD;
  logic           r_mode, r_read, r_stepA, r_stepB, r_outValid, r_inReady, r_busy;
  logic           r_resNz;

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_bitLast   = (r_bitCnt == CW'(W - 1));
  assign w_iterNext  = {1'b0, r_iter} + 5'd1;
  assign w_moreIters = (w_iterNext < 5'(ITERS));
  // The residue flag is cleared as the final compute pass begins.
  assign w_lastPassEntry = ((r_state == COMMIT) && (ITERS == 1)) ||
                           ((r_state == ITER_COMMIT) && (w_iterNext == 5'(ITERS - 1)));

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:        if (in_valid) w_nextState = LOAD;
      LOAD:        if (w_bitLast) w_nextState = COMMIT;
      COMMIT:      w_nextState = ITER;
      ITER:        if (w_bitLast) w_nextState = ITER_COMMIT;
      ITER_COMMIT: begin
        if (w_moreIters) w_nextState = ITER;
`ifdef PE_DRIVER_READBACK_EN
        else             w_nextState = READ;
`else
        else             w_nextState = DONE;
`endif
      end
`ifdef PE_DRIVER_READBACK_EN
      READ:        if (w_bitLast) w_nextState = DONE;
`endif
      DONE:        if (out_ready) w_nextState = IDLE;
      default:     w_nextState = IDLE;
    endcase
  end

`ifdef PE_DRIVER_READBACK_EN
  assign w_nextRead = (w_nextState == READ);
`else
  assign w_nextRead = 1'b0;
`endif

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bitCnt   <= '0;
      r_mode     <= 1'b0;
      r_read     <= 1'b0;
      r_stepA    <= 1'b0;
      r_stepB    <= 1'b0;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_bitCnt   <= (w_nextState != r_state) ? '0 : r_bitCnt + CW'(1);
      r_mode     <= (w_nextState == LOAD) || (w_nextState == COMMIT);
      r_read     <= w_nextRead;
      r_stepA    <= (w_nextState == LOAD) || (w_nextState == ITER);
      r_stepB    <= (w_nextState == COMMIT) || (w_nextState == ITER_COMMIT) || w_nextRead;
      r_outValid <= (w_nextState == DONE);
      r_inReady  <= (w_nextState == IDLE);
      r_busy     <= (w_nextState != IDLE);
    end
  end

  // Shift registers drain to zero during LOAD, so the serial lines idle low afterwards.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_shL <= '0;
      r_shT <= '0;
      r_shR <= '0;
      r_shD <= '0;
    end else if (w_accept) begin
      r_shL <= in_left;
      r_shT <= in_top;
      r_shR <= in_right;
      r_shD <= in_down;
    end else if (r_state == LOAD) begin
      r_shL <= {r_shL[W-2:0], 1'b0};
      r_shT <= {r_shT[W-2:0], 1'b0};
      r_shR <= {r_shR[W-2:0], 1'b0};
      r_shD <= {r_shD[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_iter  <= '0;
      r_resNz <= 1'b0;
    end else begin
      if (w_accept)
        r_iter <= '0;
      else if (r_state == ITER_COMMIT)
        r_iter <= w_iterNext[3:0];
      if (w_lastPassEntry)
        r_resNz <= 1'b0;
      else if ((r_state == ITER) && (r_iter == 4'(ITERS - 1)))
        r_resNz <= r_resNz | residue;
    end
  end

`ifdef PE_DRIVER_READBACK_EN
  logic [W-1:0] r_outSol;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n)
      r_outSol <= '0;
    else if (r_state == READ)
      r_outSol <= {r_outSol[W-2:0], solution};
  end

  assign out_solution = r_outSol;
`else
  logic w_unusedSolution;
  assign w_unusedSolution = solution;
  assign out_solution     = '0;
`endif

  assign left           = r_shL[W-1];
  assign top            = r_shT[W-1];
  assign right          = r_shR[W-1];
  assign down           = r_shD[W-1];
  assign mode           = r_mode;
  assign read           = r_read;
  assign step_a         = r_stepA;
  assign step_b         = r_stepB;
  assign out_valid      = r_outValid;
  assign in_ready       = r_inReady;
  assign busy           = r_busy;
  assign out_residue_nz = r_resNz;

endmodule
